// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Two-stage pipelined integer ALU with a valid/ready handshake on
//            both sides and a pass-through transaction tag.
//            S1 holds the captured request (a, b, op, tag).
//            S2 holds the computed result (z, flags, tag).
// Ports    : clk, rst        - clock, synchronous active-high reset
//            a, b, op, tag_i - request operands, opcode and tag
//            valid_i/ready_o - request handshake
//            z, tag_o        - result and its tag
//            zero_o          - z == 0
//            carry_o         - carry (ADD/INC) or borrow (SUB), else 0
//            illegal_o       - opcode was undefined
//            valid_o/ready_i - result handshake
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] z,
    output logic [TAG_W-1:0] tag_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             illegal_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int c_SH_W  = $clog2(WIDTH);
    // Wide enough to hold WIDTH itself (CLZ of zero, POPCNT of all ones).
    localparam int c_CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] c_OP_AND    = 4'd0;
    localparam logic [3:0] c_OP_OR     = 4'd1;
    localparam logic [3:0] c_OP_NOT    = 4'd2;
    localparam logic [3:0] c_OP_ADD    = 4'd3;
    localparam logic [3:0] c_OP_SUB    = 4'd4;
    localparam logic [3:0] c_OP_INC    = 4'd5;
    localparam logic [3:0] c_OP_SHL    = 4'd6;
    localparam logic [3:0] c_OP_SHR    = 4'd7;
    localparam logic [3:0] c_OP_POPCNT = 4'd8;
    localparam logic [3:0] c_OP_SRA    = 4'd9;
    localparam logic [3:0] c_OP_CLZ    = 4'd10;

    // Stage 1: captured request
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [3:0]       r_s1_op;
    logic [TAG_W-1:0] r_s1_tag;

    // Stage 2: registered result
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_z;
    logic [TAG_W-1:0] r_tag;
    logic             r_zero;
    logic             r_carry;
    logic             r_illegal;

    logic             w_s2_load;
    logic             w_accept;
    logic [c_SH_W-1:0] w_sh;
    logic [WIDTH:0]   w_ext;
    logic [WIDTH-1:0] w_z;
    logic             w_carry;
    logic             w_illegal;
    logic             w_zero;
    logic [c_CNT_W-1:0] w_pop;
    logic [c_CNT_W-1:0] w_clz;

    // S2 takes the S1 entry when it is empty or its result leaves this cycle.
    assign w_s2_load = r_s1_valid && (!r_s2_valid || ready_i);
    // Combinational from ready_i so a full pipe can refill on the release edge.
    assign ready_o   = !rst && (!r_s1_valid || !r_s2_valid || ready_i);
    assign w_accept  = valid_i && ready_o;
    assign w_sh      = r_s1_b[c_SH_W-1:0];
    assign w_zero    = (w_z == '0);

    always_comb begin
        w_ext     = '0;
        w_z       = '0;
        w_carry   = 1'b0;
        w_illegal = 1'b0;
        w_pop     = '0;
        w_clz     = c_CNT_W'(WIDTH);
        // Ascending scan: the highest set bit is the last one to write w_clz.
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + c_CNT_W'(r_s1_a[i]);
            if (r_s1_a[i]) begin
                w_clz = c_CNT_W'(WIDTH - 1 - i);
            end
        end
        case (r_s1_op)
            c_OP_AND: w_z = r_s1_a & r_s1_b;
            c_OP_OR:  w_z = r_s1_a | r_s1_b;
            c_OP_NOT: w_z = ~r_s1_a;
            c_OP_ADD: begin
                w_ext   = {1'b0, r_s1_a} + {1'b0, r_s1_b};
                w_z     = w_ext[WIDTH-1:0];
                w_carry = w_ext[WIDTH];
            end
            c_OP_SUB: begin
                // Bit WIDTH of the extended difference is the unsigned borrow.
                w_ext   = {1'b0, r_s1_a} - {1'b0, r_s1_b};
                w_z     = w_ext[WIDTH-1:0];
                w_carry = w_ext[WIDTH];
            end
            c_OP_INC: begin
                w_ext   = {1'b0, r_s1_a} + (WIDTH+1)'(1);
                w_z     = w_ext[WIDTH-1:0];
                w_carry = w_ext[WIDTH];
            end
            c_OP_SHL:    w_z = r_s1_a << w_sh;
            c_OP_SHR:    w_z = r_s1_a >> w_sh;
            c_OP_POPCNT: w_z = WIDTH'(w_pop);
            c_OP_SRA:    w_z = $unsigned($signed(r_s1_a) >>> w_sh);
            c_OP_CLZ:    w_z = WIDTH'(w_clz);
            default:     w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= '0;
            r_s1_tag   <= '0;
            r_s2_valid <= 1'b0;
            r_z        <= '0;
            r_tag      <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= a;
                r_s1_b     <= b;
                r_s1_op    <= op;
                r_s1_tag   <= tag_i;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end

            // Result fields only change on a load, so they hold under stall.
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_z        <= w_z;
                r_tag      <= r_s1_tag;
                r_zero     <= w_zero;
                r_carry    <= w_carry;
                r_illegal  <= w_illegal;
            end else if (ready_i) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign valid_o   = r_s2_valid;
    assign z         = r_z;
    assign tag_o     = r_tag;
    assign zero_o    = r_zero;
    assign carry_o   = r_carry;
    assign illegal_o = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Purpose  : Directed self-checking bench for alu_pipe at WIDTH=64 and
//            WIDTH=8 (two instances sharing clock and reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam logic [3:0] c_OP_AND    = 4'd0;
    localparam logic [3:0] c_OP_ADD    = 4'd3;
    localparam logic [3:0] c_OP_SUB    = 4'd4;
    localparam logic [3:0] c_OP_INC    = 4'd5;
    localparam logic [3:0] c_OP_SHL    = 4'd6;
    localparam logic [3:0] c_OP_POPCNT = 4'd8;
    localparam logic [3:0] c_OP_SRA    = 4'd9;
    localparam logic [3:0] c_OP_CLZ    = 4'd10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 64-bit instance
    logic [63:0] a, b, z;
    logic [3:0]  op, tag_i, tag_o;
    logic        valid_i, ready_o, zero_o, carry_o, illegal_o, valid_o, ready_i;

    // 8-bit instance
    logic [7:0]  a8, b8, z8;
    logic [3:0]  op8, tag_i8, tag_o8;
    logic        valid_i8, ready_o8, zero_o8, carry_o8, illegal_o8, valid_o8, ready_i8;

    int n_tests = 0;
    int n_fail  = 0;

    alu_pipe #(.WIDTH(64), .TAG_W(4)) u_dut64 (
        .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .tag_i(tag_i),
        .valid_i(valid_i), .ready_o(ready_o), .z(z), .tag_o(tag_o),
        .zero_o(zero_o), .carry_o(carry_o), .illegal_o(illegal_o),
        .valid_o(valid_o), .ready_i(ready_i)
    );

    alu_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .op(op8), .tag_i(tag_i8),
        .valid_i(valid_i8), .ready_o(ready_o8), .z(z8), .tag_o(tag_o8),
        .zero_o(zero_o8), .carry_o(carry_o8), .illegal_o(illegal_o8),
        .valid_o(valid_o8), .ready_i(ready_i8)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                        input logic [3:0] t);
        op = o; a = x; b = y; tag_i = t; valid_i = 1'b1;
        step();
    endtask

    task automatic send8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] t);
        op8 = o; a8 = x; b8 = y; tag_i8 = t; valid_i8 = 1'b1;
        step();
    endtask

    // Global time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        a = '0; b = '0; op = '0; tag_i = '0; valid_i = 1'b0; ready_i = 1'b1;
        a8 = '0; b8 = '0; op8 = '0; tag_i8 = '0; valid_i8 = 1'b0; ready_i8 = 1'b1;

        // ---- reset state ----
        step(); step();
        chk("rst_valid_o", 64'(valid_o), 64'd0);
        chk("rst_z",       z,            64'd0);
        chk("rst_tag_o",   64'(tag_o),   64'd0);
        chk("rst_flags",   64'({zero_o, carry_o, illegal_o}), 64'd0);
        chk("rst_ready_o", 64'(ready_o), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready_o", 64'(ready_o), 64'd1);

        // ---- ADD overflow, 2-cycle latency ----
        send(c_OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd3);
        valid_i = 1'b0;
        chk("add_not_yet_valid", 64'(valid_o), 64'd0);
        step();
        chk("add_valid", 64'(valid_o), 64'd1);
        chk("add_z",     z,            64'd0);
        chk("add_zero",  64'(zero_o),  64'd1);
        chk("add_carry", 64'(carry_o), 64'd1);
        chk("add_tag",   64'(tag_o),   64'd3);

        // ---- back-to-back stream, one result per cycle ----
        send(c_OP_SUB, 64'd5, 64'd7, 4'd4);
        send(c_OP_POPCNT, 64'hF0F0, 64'd0, 4'd5);
        chk("sub_z",     z,            64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_carry", 64'(carry_o), 64'd1);
        chk("sub_tag",   64'(tag_o),   64'd4);
        send(c_OP_CLZ, 64'd0, 64'd0, 4'd6);
        chk("popcnt_z",     z,            64'd8);
        chk("popcnt_carry", 64'(carry_o), 64'd0);
        chk("popcnt_tag",   64'(tag_o),   64'd5);
        send(c_OP_SRA, 64'h8000_0000_0000_0000, 64'h43, 4'd7);
        chk("clz_z",   z,          64'd64);
        chk("clz_tag", 64'(tag_o), 64'd6);
        send(4'd12, 64'h1234, 64'h5678, 4'd8);
        chk("sra_z",   z,          64'hF000_0000_0000_0000);
        chk("sra_tag", 64'(tag_o), 64'd7);
        send(c_OP_AND, 64'hF0F0, 64'hFF00, 4'd9);
        chk("ill_illegal", 64'(illegal_o), 64'd1);
        chk("ill_z",       z,              64'd0);
        chk("ill_zero",    64'(zero_o),    64'd1);
        chk("ill_carry",   64'(carry_o),   64'd0);
        chk("ill_tag",     64'(tag_o),     64'd8);
        valid_i = 1'b0;
        step();
        chk("and_z",       z,              64'hF000);
        chk("and_illegal", 64'(illegal_o), 64'd0);
        chk("and_zero",    64'(zero_o),    64'd0);
        chk("and_tag",     64'(tag_o),     64'd9);
        step();
        chk("drain_valid", 64'(valid_o), 64'd0);

        // ---- backpressure: capacity 2, in-order release ----
        ready_i = 1'b0;
        send(c_OP_ADD, 64'd10, 64'd1, 4'd1);
        chk("bp_ready_after1", 64'(ready_o), 64'd1);
        send(c_OP_ADD, 64'd20, 64'd1, 4'd2);
        chk("bp_ready_after2", 64'(ready_o), 64'd0);
        chk("bp_valid",        64'(valid_o), 64'd1);
        op = c_OP_ADD; a = 64'd30; b = 64'd1; tag_i = 4'd3; valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("bp_hold_tag",   64'(tag_o),   64'd1);
            chk("bp_hold_z",     z,            64'd11);
            chk("bp_hold_ready", 64'(ready_o), 64'd0);
        end
        ready_i = 1'b1;
        #1;
        chk("bp_ready_comb", 64'(ready_o), 64'd1);
        step();
        valid_i = 1'b0;
        chk("bp_second_tag", 64'(tag_o), 64'd2);
        chk("bp_second_z",   z,          64'd21);
        step();
        chk("bp_third_tag",  64'(tag_o), 64'd3);
        chk("bp_third_z",    z,          64'd31);
        step();
        chk("bp_drain_valid", 64'(valid_o), 64'd0);

        // ---- reset with two requests in flight ----
        ready_i = 1'b0;
        send(c_OP_ADD, 64'd100, 64'd1, 4'd10);
        send(c_OP_ADD, 64'd200, 64'd1, 4'd11);
        chk("inflight_valid", 64'(valid_o), 64'd1);
        rst = 1'b1;
        valid_i = 1'b0;
        step();
        chk("midrst_valid", 64'(valid_o), 64'd0);
        chk("midrst_z",     z,            64'd0);
        chk("midrst_ready", 64'(ready_o), 64'd0);
        rst = 1'b0;
        ready_i = 1'b1;
        #1;
        chk("midrst_release_ready", 64'(ready_o), 64'd1);
        step();
        chk("no_stale_1", 64'(valid_o), 64'd0);
        step();
        chk("no_stale_2", 64'(valid_o), 64'd0);

        // ---- WIDTH=8 instance ----
        send8(c_OP_SHL, 8'h81, 8'hF9, 4'd1);
        send8(c_OP_INC, 8'hFF, 8'h00, 4'd2);
        chk("w8_shl_z",     64'(z8),       64'h02);
        chk("w8_shl_carry", 64'(carry_o8), 64'd0);
        chk("w8_shl_tag",   64'(tag_o8),   64'd1);
        send8(c_OP_CLZ, 8'h10, 8'h00, 4'd3);
        chk("w8_inc_z",     64'(z8),       64'h00);
        chk("w8_inc_carry", 64'(carry_o8), 64'd1);
        chk("w8_inc_zero",  64'(zero_o8),  64'd1);
        send8(c_OP_SUB, 8'h07, 8'h05, 4'd4);
        chk("w8_clz_z",     64'(z8),       64'd3);
        valid_i8 = 1'b0;
        step();
        chk("w8_sub_z",     64'(z8),       64'd2);
        chk("w8_sub_carry", 64'(carry_o8), 64'd0);
        chk("w8_sub_tag",   64'(tag_o8),   64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
